// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer
//   Control FSM for one fully-connected layer pass. Fetches the layer header
//   and per-neuron bias from the network-structure block, requests weight
//   chunks, streams INPUTS_MAC activations per chunk into the PE_FC MAC array,
//   accumulates one neuron at a time, then adds bias, requantizes (arithmetic
//   right shift), optionally applies ReLU, saturates to int8 and writes the
//   result to output-feature memory.
//
//   state | meaning
//   IDLE  | waiting for start
//   HDR   | waiting for layer header + first bias
//   REQW  | get_weight pulse
//   WAITW | waiting for weight chunk
//   ADDR  | compute activation read addresses for chunk c
//   RD    | synchronous memory read in flight
//   LOAD  | drive activations/weights, write_kernel pulse
//   MACW  | wait MAC_LAT cycles for macs_result
//   ACC   | accumulate, advance chunk counter
//   OUT   | requantize and write one output byte
//   NEXT  | next neuron / next layer / done decision
//   WAITB | waiting for next neuron bias
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 begin one layer pass (IDLE only)
//   cant_inputs .. frac   layer header from the structure block
//   struct_ready          header/kernel/bias valid
//   next_layer/next_neuron/get_weight  one-cycle request pulses
//   kernel, bias          weight chunk and signed neuron bias
//   weights2arr, if_data, write_kernel, macs_result  MAC array interface
//   if_base_in, if_address, if_data_memory           activation memory
//   en_w, of_write, of_w_address, of_read, of_r_address  output memory
module fc_layer_sequencer #(
  parameter int ADDRESS_BITS = 6,
  parameter int COLS_MAC     = 4,
  parameter int INPUTS_MAC   = 6,
  parameter int MAC_LAT      = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [7:0]                                 cant_inputs,
  input  logic [15:0]                                iters_per_neuron,
  input  logic [7:0]                                 modulo,
  input  logic [7:0]                                 cant_neurons,
  input  logic [7:0]                                 last,
  input  logic [15:0]                                of_offset,
  input  logic [7:0]                                 n,
  input  logic [7:0]                                 frac,
  input  logic                                       struct_ready,
  output logic                                       next_layer,
  output logic                                       next_neuron,
  output logic                                       get_weight,
  input  logic [INPUTS_MAC-1:0][7:0]                 kernel,
  input  logic signed [31:0]                         bias,
  output logic [INPUTS_MAC-1:0][7:0]                 weights2arr,
  output logic                                       write_kernel,
  input  logic [ADDRESS_BITS-1:0]                    if_base_in,
  input  logic signed [31:0]                         macs_result,
  output logic [COLS_MAC-1:0]                        en_w,
  output logic [INPUTS_MAC-1:0][7:0]                 if_data,
  input  logic [INPUTS_MAC-1:0][7:0]                 if_data_memory,
  output logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0]    if_address,
  output logic [COLS_MAC-1:0][7:0]                   of_write,
  output logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]      of_w_address,
  input  logic [COLS_MAC-1:0][7:0]                   of_read,
  output logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]      of_r_address
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    HDR   = 4'd1,
    REQW  = 4'd2,
    WAITW = 4'd3,
    ADDR  = 4'd4,
    RD    = 4'd5,
    LOAD  = 4'd6,
    MACW  = 4'd7,
    ACC   = 4'd8,
    OUT   = 4'd9,
    NEXT  = 4'd10,
    WAITB = 4'd11
  } state_t;

  state_t state_q, state_d;

  // Set for the cycle right after any request pulse so the struct block gets
  // one cycle to drop a stale struct_ready before it is sampled.
  logic skip_q;

  logic [15:0]                                 iters_q;
  logic [7:0]                                  modulo_q;
  logic [7:0]                                  neurons_q;
  logic                                        last_q;
  logic [ADDRESS_BITS-1:0]                     offset_q;
  logic [7:0]                                  frac_q;
  logic signed [31:0]                          bias_q;
  logic [INPUTS_MAC-1:0][7:0]                  kernel_q;
  logic [7:0]                                  neuron_q;
  logic [15:0]                                 c_q;
  logic signed [31:0]                          acc_q;
  logic [7:0]                                  lat_q;
  logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0]     addr_q;

  logic                                        take;
  logic                                        hdr_empty;
  logic                                        more_neurons;
  logic                                        more_chunks;
  logic                                        last_chunk;
  logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0]     addr_calc;
  logic signed [31:0]                          sum;
  logic signed [31:0]                          shifted;
  logic signed [31:0]                          clipped;
  logic [7:0]                                  result;
  logic [ADDRESS_BITS-1:0]                     wr_addr;
  int                                          lane_sel;

  logic unused_inputs;
  assign unused_inputs = ^{of_read, n, cant_inputs, of_offset};

  assign take         = !skip_q && struct_ready;
  assign hdr_empty    = (iters_per_neuron == 16'd0) || (cant_neurons == 8'd0);
  assign more_neurons = (iters_q != 16'd0) &&
                        (({1'b0, neuron_q} + 9'd1) < {1'b0, neurons_q});
  assign more_chunks  = (({1'b0, c_q} + 17'd1) < {1'b0, iters_q});
  assign last_chunk   = (c_q == iters_q - 16'd1);
  assign if_address   = addr_q;
  assign of_r_address = '0;

  always_comb begin
    addr_calc = '0;
    for (int i = 0; i < INPUTS_MAC; i++) begin
      addr_calc[i] = ADDRESS_BITS'(32'(if_base_in) + 32'(c_q) * 32'(INPUTS_MAC) + 32'(i));
    end
  end

  // Requantization: 32-bit wrap on the bias add, arithmetic shift, optional
  // ReLU, then int8 saturation.
  always_comb begin
    sum     = acc_q + bias_q;
    shifted = sum >>> frac_q;
    clipped = shifted;
    if (!last_q && shifted < 0) begin
      clipped = 32'sd0;
    end
    if (clipped > 32'sd127) begin
      result = 8'h7F;
    end else if (clipped < -32'sd128) begin
      result = 8'h80;
    end else begin
      result = clipped[7:0];
    end
    wr_addr  = offset_q + ADDRESS_BITS'(32'(neuron_q) / 32'(COLS_MAC));
    lane_sel = int'(32'(neuron_q) % 32'(COLS_MAC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    next_layer   = 1'b0;
    next_neuron  = 1'b0;
    get_weight   = 1'b0;
    write_kernel = 1'b0;
    en_w         = '0;
    weights2arr  = '0;
    if_data      = '0;
    of_write     = '0;
    of_w_address = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        if (take) state_d = hdr_empty ? NEXT : REQW;
      end
      REQW: begin
        get_weight = 1'b1;
        state_d    = WAITW;
      end
      WAITW: begin
        if (take) state_d = ADDR;
      end
      ADDR: state_d = RD;
      RD:   state_d = LOAD;
      LOAD: begin
        write_kernel = 1'b1;
        weights2arr  = kernel_q;
        for (int i = 0; i < INPUTS_MAC; i++) begin
          // Lanes past the remainder of a partial final chunk carry no input.
          if (!(last_chunk && modulo_q != 8'd0 && 32'(i) >= 32'(modulo_q))) begin
            if_data[i] = if_data_memory[i];
          end
        end
        state_d = MACW;
      end
      MACW: begin
        if (lat_q == 8'd0) state_d = ACC;
      end
      ACC: begin
        state_d = more_chunks ? REQW : OUT;
      end
      OUT: begin
        for (int k = 0; k < COLS_MAC; k++) begin
          if (k == lane_sel) begin
            en_w[k]         = 1'b1;
            of_write[k]     = result;
            of_w_address[k] = wr_addr;
          end
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (more_neurons) begin
          next_neuron = 1'b1;
          state_d     = WAITB;
        end else if (last_q) begin
          state_d = IDLE;
        end else begin
          next_layer = 1'b1;
          state_d    = HDR;
        end
      end
      WAITB: begin
        if (take) state_d = REQW;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q    <= 1'b0;
      iters_q   <= '0;
      modulo_q  <= '0;
      neurons_q <= '0;
      last_q    <= 1'b0;
      offset_q  <= '0;
      frac_q    <= '0;
      bias_q    <= '0;
      kernel_q  <= '0;
      neuron_q  <= '0;
      c_q       <= '0;
      acc_q     <= '0;
      lat_q     <= '0;
      addr_q    <= '0;
    end else begin
      skip_q <= get_weight | next_neuron | next_layer;
      case (state_q)
        HDR: begin
          if (take) begin
            iters_q   <= iters_per_neuron;
            modulo_q  <= modulo;
            neurons_q <= cant_neurons;
            last_q    <= (last != 8'd0);
            offset_q  <= of_offset[ADDRESS_BITS-1:0];
            frac_q    <= frac;
            bias_q    <= bias;
            neuron_q  <= '0;
            c_q       <= '0;
            acc_q     <= '0;
          end
        end
        WAITW: begin
          if (take) kernel_q <= kernel;
        end
        ADDR: addr_q <= addr_calc;
        LOAD: lat_q <= 8'(MAC_LAT - 1);
        MACW: begin
          if (lat_q != 8'd0) lat_q <= lat_q - 8'd1;
        end
        ACC: begin
          acc_q <= acc_q + macs_result;
          c_q   <= c_q + 16'd1;
        end
        NEXT: begin
          if (more_neurons) begin
            neuron_q <= neuron_q + 8'd1;
            c_q      <= '0;
            acc_q    <= '0;
          end
        end
        WAITB: begin
          if (take) bias_q <= bias;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed testbench for fc_layer_sequencer with a synchronous-read
// activation memory model and a one-cycle MAC array model.
module tb_fc_layer_sequencer;

  logic clk = 1'b0;
  logic rst, start, struct_ready;
  logic [7:0] cant_inputs, modulo, cant_neurons, last, n, frac;
  logic [15:0] iters_per_neuron, of_offset;
  logic [5:0][7:0] kernel;
  logic signed [31:0] bias;
  logic signed [31:0] macs_result;
  logic [5:0] if_base_in;
  logic [5:0][7:0] if_data_memory;
  logic [3:0][7:0] of_read;
  logic next_layer, next_neuron, get_weight, write_kernel;
  logic [5:0][7:0] weights2arr, if_data;
  logic [3:0] en_w;
  logic [5:0][5:0] if_address;
  logic [3:0][7:0] of_write;
  logic [3:0][5:0] of_w_address, of_r_address;

  logic [7:0] mem [64];

  int checks = 0;
  int errors = 0;
  int gw_cnt = 0, wk_cnt = 0, nn_cnt = 0, nl_cnt = 0, wr_cnt = 0, onehot_bad = 0;
  int wr_lane [32];
  logic [7:0] wr_data [32];
  logic [5:0] wr_addr [32];
  logic [5:0][7:0] last_if_data;
  logic [5:0][5:0] last_if_addr;

  always #5 clk = ~clk;

  fc_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cant_inputs(cant_inputs),
    .iters_per_neuron(iters_per_neuron), .modulo(modulo), .cant_neurons(cant_neurons),
    .last(last), .of_offset(of_offset), .n(n), .frac(frac), .struct_ready(struct_ready),
    .next_layer(next_layer), .next_neuron(next_neuron), .get_weight(get_weight),
    .kernel(kernel), .bias(bias), .weights2arr(weights2arr), .write_kernel(write_kernel),
    .if_base_in(if_base_in), .macs_result(macs_result), .en_w(en_w), .if_data(if_data),
    .if_data_memory(if_data_memory), .if_address(if_address), .of_write(of_write),
    .of_w_address(of_w_address), .of_read(of_read), .of_r_address(of_r_address)
  );

  function automatic logic signed [31:0] dot(input logic [5:0][7:0] a, input logic [5:0][7:0] w);
    int s = 0;
    for (int i = 0; i < 6; i++) s += int'($signed(a[i])) * int'($signed(w[i]));
    return s;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) if_data_memory[i] <= mem[if_address[i]];
    if (write_kernel) macs_result <= dot(if_data, weights2arr);
  end

  always @(negedge clk) begin
    if (get_weight) gw_cnt++;
    if (next_neuron) nn_cnt++;
    if (next_layer) nl_cnt++;
    if (write_kernel) begin
      wk_cnt++;
      last_if_data = if_data;
      last_if_addr = if_address;
    end
    if (en_w != 4'b0) begin
      if (!$onehot(en_w)) onehot_bad++;
      for (int k = 0; k < 4; k++) begin
        if (en_w[k] && wr_cnt < 32) begin
          wr_lane[wr_cnt] = k;
          wr_data[wr_cnt] = of_write[k];
          wr_addr[wr_cnt] = of_w_address[k];
        end
      end
      wr_cnt++;
    end
  end

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic fill_kernel(input logic [7:0] v);
    for (int i = 0; i < 6; i++) kernel[i] = v;
  endtask

  task automatic set_hdr(input logic [15:0] it, input logic [7:0] md, input logic [7:0] nr,
                         input logic [7:0] ls, input logic [15:0] off, input logic [7:0] fr,
                         input logic signed [31:0] b);
    iters_per_neuron = it; modulo = md; cant_neurons = nr; last = ls;
    of_offset = off; frac = fr; bias = b;
    cant_inputs = 8'(it * 6);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    struct_ready = 1'b1;
  endtask

  task automatic run_layer(input bit to_hdr, output bit ok);
    ok = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (to_hdr && next_layer) begin
        struct_ready = 1'b0;
        ok = 1'b1;
        break;
      end
      if (!to_hdr && dut.state_q == 4'd0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({next_layer, next_neuron, get_weight, write_kernel, en_w, weights2arr, if_data,
         if_address, of_write, of_w_address, of_r_address} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs");
    end
    checks++;
    if (dut.state_q !== 4'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", dut.state_q);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== 4'd0) begin
      errors++; $display("FAIL start_in_reset got %0d exp 0", dut.state_q);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int gw0 = gw_cnt, wk0 = wk_cnt, wr0 = wr_cnt;
    fill_mem(8'd1); fill_kernel(8'd2); if_base_in = 6'd0;
    set_hdr(16'd1, 8'd0, 8'd1, 8'd1, 16'd5, 8'd0, 32'sd0);
    run_layer(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got busy exp idle"); end
    checks++;
    if (wk_cnt - wk0 !== 1) begin errors++; $display("FAIL basic_wk got %0d exp 1", wk_cnt - wk0); end
    checks++;
    if (gw_cnt - gw0 !== 1) begin errors++; $display("FAIL basic_gw got %0d exp 1", gw_cnt - gw0); end
    checks++;
    if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL basic_writes got %0d exp 1", wr_cnt - wr0); end
    checks++;
    if (wr_lane[wr0] !== 0 || wr_data[wr0] !== 8'd12 || wr_addr[wr0] !== 6'd5) begin
      errors++; $display("FAIL basic_write got lane %0d data %0d addr %0d exp 0 12 5",
                         wr_lane[wr0], wr_data[wr0], wr_addr[wr0]);
    end
  endtask

  task automatic test_partial_chunk();
    bit ok;
    int gw0 = gw_cnt, wk0 = wk_cnt, wr0 = wr_cnt;
    fill_mem(8'd1); fill_kernel(8'd1); if_base_in = 6'd60;
    set_hdr(16'd2, 8'd2, 8'd1, 8'd1, 16'h0113, 8'd0, 32'sd0);
    cant_inputs = 8'd8;
    run_layer(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL partial_timeout got busy exp idle"); end
    checks++;
    if (gw_cnt - gw0 !== 2 || wk_cnt - wk0 !== 2) begin
      errors++; $display("FAIL partial_pulses got gw %0d wk %0d exp 2 2", gw_cnt - gw0, wk_cnt - wk0);
    end
    checks++;
    if (last_if_data !== 48'h0000_0000_0101) begin
      errors++; $display("FAIL partial_mask got %h exp 000000000101", last_if_data);
    end
    checks++;
    if (last_if_addr[0] !== 6'd2 || last_if_addr[5] !== 6'd7) begin
      errors++; $display("FAIL partial_addr got %0d %0d exp 2 7", last_if_addr[0], last_if_addr[5]);
    end
    checks++;
    if (wr_data[wr0] !== 8'd8 || wr_addr[wr0] !== 6'd19) begin
      errors++; $display("FAIL partial_result got data %0d addr %0d exp 8 19", wr_data[wr0], wr_addr[wr0]);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int wr0 = wr_cnt;
    fill_mem(8'd50); fill_kernel(8'd1); if_base_in = 6'd0;
    set_hdr(16'd1, 8'd0, 8'd1, 8'd1, 16'd0, 8'd1, 32'sd0);
    run_layer(1'b0, ok);
    checks++;
    if (!ok || wr_data[wr0] !== 8'h7F) begin
      errors++; $display("FAIL sat_pos got %h exp 7f", wr_data[wr0]);
    end
    fill_mem(8'd100); fill_kernel(8'hFE);
    set_hdr(16'd1, 8'd0, 8'd1, 8'd1, 16'd0, 8'd0, 32'sd0);
    run_layer(1'b0, ok);
    checks++;
    if (!ok || wr_data[wr0 + 1] !== 8'h80) begin
      errors++; $display("FAIL sat_neg got %h exp 80", wr_data[wr0 + 1]);
    end
  endtask

  task automatic test_relu();
    bit ok;
    int wr0 = wr_cnt, nl0 = nl_cnt;
    fill_mem(8'd10); kernel = '0; kernel[0] = 8'hFE; if_base_in = 6'd0;
    set_hdr(16'd1, 8'd0, 8'd1, 8'd0, 16'd0, 8'd0, 32'sd0);
    run_layer(1'b1, ok);
    checks++;
    if (!ok || wr_data[wr0] !== 8'h00) begin
      errors++; $display("FAIL relu_clamp got %h exp 00", wr_data[wr0]);
    end
    checks++;
    if (nl_cnt - nl0 !== 1 || dut.state_q !== 4'd1) begin
      errors++; $display("FAIL relu_next_layer got %0d state %0d exp 1 1", nl_cnt - nl0, dut.state_q);
    end
    do_reset();
    set_hdr(16'd1, 8'd0, 8'd1, 8'd1, 16'd0, 8'd0, 32'sd0);
    run_layer(1'b0, ok);
    checks++;
    if (!ok || wr_data[wr0 + 1] !== 8'hEC) begin
      errors++; $display("FAIL last_negative got %h exp ec", wr_data[wr0 + 1]);
    end
    set_hdr(16'd1, 8'd0, 8'd1, 8'd1, 16'd0, 8'd1, 32'sd4);
    run_layer(1'b0, ok);
    checks++;
    if (!ok || wr_data[wr0 + 2] !== 8'hF8) begin
      errors++; $display("FAIL bias_shift got %h exp f8", wr_data[wr0 + 2]);
    end
  endtask

  task automatic test_multi_neuron();
    bit ok;
    int exp_lane [5] = '{0, 1, 2, 3, 0};
    logic [5:0] exp_addr [5] = '{6'd8, 6'd8, 6'd8, 6'd8, 6'd9};
    int wr0 = wr_cnt, nn0 = nn_cnt, nl0 = nl_cnt;
    fill_mem(8'd1); fill_kernel(8'd1); if_base_in = 6'd0;
    set_hdr(16'd1, 8'd0, 8'd5, 8'd0, 16'd8, 8'd0, 32'sd0);
    run_layer(1'b1, ok);
    checks++;
    if (!ok || wr_cnt - wr0 !== 5) begin
      errors++; $display("FAIL multi_writes got %0d exp 5", wr_cnt - wr0);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (wr_lane[wr0 + j] !== exp_lane[j] || wr_addr[wr0 + j] !== exp_addr[j] ||
          wr_data[wr0 + j] !== 8'd6) begin
        errors++; $display("FAIL multi_write%0d got lane %0d addr %0d data %0d exp %0d %0d 6",
                           j, wr_lane[wr0 + j], wr_addr[wr0 + j], wr_data[wr0 + j],
                           exp_lane[j], exp_addr[j]);
      end
    end
    checks++;
    if (nn_cnt - nn0 !== 4 || nl_cnt - nl0 !== 1) begin
      errors++; $display("FAIL multi_pulses got nn %0d nl %0d exp 4 1", nn_cnt - nn0, nl_cnt - nl0);
    end
    checks++;
    if (dut.state_q !== 4'd1) begin
      errors++; $display("FAIL multi_hdr got %0d exp 1", dut.state_q);
    end
    checks++;
    if (onehot_bad !== 0) begin
      errors++; $display("FAIL en_w_onehot got %0d exp 0", onehot_bad);
    end
    do_reset();
  endtask

  task automatic test_reset_in_macw();
    bit seen = 1'b0;
    int wr0 = wr_cnt;
    fill_mem(8'd1); fill_kernel(8'd1); if_base_in = 6'd0;
    set_hdr(16'd1, 8'd0, 8'd1, 8'd1, 16'd0, 8'd0, 32'sd0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (dut.state_q == 4'd7) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL macw_reach got none exp state 7"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.state_q !== 4'd0) begin
      errors++; $display("FAIL macw_abort got %0d exp 0", dut.state_q);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt - wr0 !== 0 || dut.state_q !== 4'd0) begin
      errors++; $display("FAIL macw_no_write got %0d state %0d exp 0 0", wr_cnt - wr0, dut.state_q);
    end
  endtask

  task automatic test_empty_layer();
    bit ok;
    int gw0 = gw_cnt, wr0 = wr_cnt;
    set_hdr(16'd0, 8'd0, 8'd3, 8'd1, 16'd0, 8'd0, 32'sd0);
    run_layer(1'b0, ok);
    checks++;
    if (!ok || gw_cnt - gw0 !== 0 || wr_cnt - wr0 !== 0) begin
      errors++; $display("FAIL empty_layer got gw %0d wr %0d exp 0 0", gw_cnt - gw0, wr_cnt - wr0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; struct_ready = 1'b1;
    n = 8'd3; of_read = '0; kernel = '0; if_base_in = '0;
    set_hdr(16'd0, 8'd0, 8'd0, 8'd0, 16'd0, 8'd0, 32'sd0);
    fill_mem(8'd0);
    test_reset();
    test_basic();
    test_partial_chunk();
    test_saturate();
    test_relu();
    test_multi_neuron();
    test_reset_in_macw();
    test_empty_layer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
